cacheline_adaptor: RTL and testbench
====================================

// Module: cacheline_adaptor
// PURPOSE
//   Memory-side responder for the cache's pmem_* port. Accepts one full-line read or
//   write request (address + line width data) and performs it as a fixed-length burst
//   of narrower beats on the physical memory bus. Sits between the cache (pmem_* side)
//   and the burst DRAM model or controller.
// PARAMETERS
//   s_line   256  line width in bits; matches pmem_rdata/pmem_wdata
//   s_burst  64   beat width in bits; s_line must be an integer multiple of s_burst
//   (derived) BEATS = s_line/s_burst (default 4); s_offset = log2(s_line/8) = 5
// PORTS
//   clk         in   1        clock
//   rst         in   1        synchronous, active-high reset
//   line_i      in   s_line   write line from cache (pmem_wdata)
//   line_o      out  s_line   assembled read line to cache (pmem_rdata)
//   address_i   in   32       line request address (pmem_address)
//   read_i      in   1        line read request (pmem_read)
//   write_i     in   1        line write request (pmem_write)
//   resp_o      out  1        line transfer complete (pmem_resp)
//   burst_i     in   s_burst  read beat data from memory
//   burst_o     out  s_burst  write beat data to memory
//   address_o   out  32       burst address, low s_offset bits forced to 0
//   read_o      out  1        burst read request
//   write_o     out  1        burst write request
//   resp_i      in   1        beat valid/accepted strobe from memory
// BEHAVIOUR
//   Reset: state=IDLE, beat counter=0, line buffer=0; line_o=0, burst_o=0, address_o=0,
//     read_o=0, write_o=0, resp_o=0. Reset mid-burst aborts immediately, no resp_o.
//   States: IDLE, RD, WR, DONE.
//   IDLE: write_i=1 -> latch address_i & ~(2^s_offset-1), latch line_i, cnt=0, go WR.
//     else read_i=1 -> latch aligned address, cnt=0, go RD. write_i has priority if both.
//     resp_i in IDLE ignored.
//   RD: read_o=1, address_o=latched addr. Each cycle resp_i=1: buffer bits
//     [cnt*s_burst +: s_burst] <= burst_i, cnt++. Cycles with resp_i=0 are stalls (no
//     advance). On the beat with cnt=BEATS-1 -> DONE; read_o drops in DONE.
//   WR: write_o=1, address_o=latched addr, burst_o=line[cnt*s_burst +: s_burst]
//     (combinational from cnt; beat 0 valid on first WR cycle). resp_i=1 advances cnt;
//     on beat BEATS-1 -> DONE.
//   DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, then IDLE unconditionally.
//     read_i/write_i/resp_i ignored in DONE (cache drops request the cycle after resp_o).
//   line_o = line buffer; stable from DONE until a later read's first beat lands.
//     Write transfers do not modify line_o.
//   Latency: request seen in IDLE at cycle t, zero-stall memory -> beats t+1..t+BEATS,
//     resp_o at t+BEATS+1. Minimum line turnaround BEATS+2 cycles.
//   address_i/line_i changes after acceptance have no effect on the current transfer.
//   cnt is log2(BEATS) bits; wraps to 0 on leaving RD/WR.
// TESTING
//   1 read 0x0000_1234, resp_i 4 consecutive beats D0..D3 -> address_o=0x0000_1220,
//     resp_o one cycle at t+5, line_o={D3,D2,D1,D0}, read_o low in resp cycle.
//   2 write line L to 0x8000_0040, resp_i every cycle -> burst_o=L[63:0],L[127:64],
//     L[191:128],L[255:192] on successive beats; write_o=1 for 4 cycles; resp_o at t+5.
//   3 read with resp_i gaps (1,0,0,1,1,0,1) -> 4 beats captured in order, resp_o one
//     cycle after 4th accepted beat, read_o held through stalls.
//   4 read_i=write_i=1 in IDLE -> write burst performed, read_o never asserted; resp_i
//     pulses in IDLE -> no state change, no resp_o.
//   5 rst asserted after 2nd read beat -> next cycle all outputs 0, state IDLE;
//     following read completes normally with correct line_o.
//   6 back-to-back: read done, write done, read -> each resp_o exactly one cycle,
//     line_o unchanged across the write.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one full-line cache read/write into a fixed-length burst of beats
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   line_i, line_o            write line from cache, assembled read line to cache
//   address_i, read_i, write_i, resp_o   cache-side request and completion pulse
//   burst_i, burst_o          read beat from memory, write beat to memory
//   address_o, read_o, write_o, resp_i   memory-side burst request and beat strobe
module cacheline_adaptor #(
    parameter int s_line   = 256,
    parameter int s_burst  = 64,
    parameter int s_offset = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    localparam int beats = s_line / s_burst;
    localparam int cw = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [cw-1:0] last = cw'(beats - 1);
    localparam logic [31:0] mask = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_n;
    logic [cw-1:0]     cnt;
    logic [31:0]       addr;
    logic [s_line-1:0] rbuf;
    logic [s_line-1:0] wbuf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            rbuf  <= '0;
            wbuf  <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (write_i || read_i) begin
                        addr <= address_i & mask;
                        cnt  <= '0;
                    end
                    if (write_i) wbuf <= line_i;
                end
                RD: if (resp_i) begin
                    rbuf[cnt*s_burst +: s_burst] <= burst_i;
                    cnt <= (cnt == last) ? '0 : cnt + 1'b1;
                end
                WR: if (resp_i) cnt <= (cnt == last) ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = write_i ? WR : (read_i ? RD : IDLE);
            RD, WR:  state_n = (resp_i && cnt == last) ? DONE : state;
            default: state_n = IDLE;
        endcase
    end

    assign read_o    = state == RD;
    assign write_o   = state == WR;
    assign resp_o    = state == DONE;
    assign address_o = (read_o || write_o) ? addr : '0;
    assign burst_o   = write_o ? wbuf[cnt*s_burst +: s_burst] : '0;
    assign line_o    = rbuf;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: transaction-level model plus directed line reads/writes
module tb_cacheline_adaptor;
    logic         clk = 0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
    logic [63:0]  burst_i, burst_o;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a line transfer in flight is (kind, beats still owed); one completion cycle follows it.
    int           m_kind = 0;  // 0 none, 1 read, 2 write
    int           m_left = 0;
    bit           m_done = 0;
    logic [31:0]  m_addr = 0;
    logic [255:0] m_wline = 0;
    logic [255:0] m_rline = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_kind <= 0; m_left <= 0; m_done <= 0; m_addr <= 0; m_rline <= 0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (m_kind != 0) begin
            if (resp_i) begin
                if (m_kind == 1) m_rline[(4-m_left)*64 +: 64] <= burst_i;
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_kind <= 0;
                    m_done <= 1;
                end
            end
        end else if (write_i || read_i) begin
            m_kind  <= write_i ? 2 : 1;
            m_left  <= 4;
            m_addr  <= {address_i[31:5], 5'd0};
            if (write_i) m_wline <= line_i;
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("read_o", read_o, m_kind == 1);
        check("write_o", write_o, m_kind == 2);
        check("resp_o", resp_o, m_done);
        check("address_o", address_o, m_kind != 0 ? m_addr : 32'd0);
        check("burst_o", burst_o, m_kind == 2 ? m_wline[(4-m_left)*64 +: 64] : 64'd0);
        check("line_o", line_o, m_rline);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d);
        resp_i = 1; burst_i = d; cyc(); resp_i = 0; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    localparam logic [255:0] L = {64'hDDDD_4444_DDDD_4444, 64'hCCCC_3333_CCCC_3333,
                                  64'hBBBB_2222_BBBB_2222, 64'hAAAA_1111_AAAA_1111};
    logic [63:0] d [4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
                           64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
    logic [255:0] saved;

    initial begin
        rst = 1; line_i = 0; address_i = 0; read_i = 0; write_i = 0; resp_i = 0; burst_i = 0;
        cyc(); cyc();
        chk_en = 1;
        check("reset resp_o", resp_o, 0);
        check("reset line_o", line_o, 0);
        check("reset address_o", address_o, 0);
        rst = 0;
        cyc();
        // 1: aligned read, zero-stall beats
        read_i = 1; address_i = 32'h0000_1234; cyc(); read_i = 0; address_i = 32'hFFFF_FFFF;
        check("t1 address_o", address_o, 32'h0000_1220);
        check("t1 read_o", read_o, 1);
        for (int i = 0; i < 4; i++) beat(d[i]);
        check("t1 resp_o", resp_o, 1);
        check("t1 read_o in resp", read_o, 0);
        check("t1 line_o", line_o, {d[3], d[2], d[1], d[0]});
        cyc();
        check("t1 resp_o one cycle", resp_o, 0);
        // 2: write, beats in ascending order
        write_i = 1; address_i = 32'h8000_0040; line_i = L; cyc(); write_i = 0; line_i = '1;
        check("t2 address_o", address_o, 32'h8000_0040);
        check("t2 beat0", burst_o, 64'hAAAA_1111_AAAA_1111);
        beat(0);
        check("t2 beat1", burst_o, 64'hBBBB_2222_BBBB_2222);
        beat(0);
        check("t2 beat2", burst_o, 64'hCCCC_3333_CCCC_3333);
        beat(0);
        check("t2 beat3", burst_o, 64'hDDDD_4444_DDDD_4444);
        beat(0);
        check("t2 resp_o", resp_o, 1);
        check("t2 line_o kept", line_o, {d[3], d[2], d[1], d[0]});
        cyc();
        // 3: read with stalls 1,0,0,1,1,0,1
        read_i = 1; address_i = 32'h0000_0FFF; cyc(); read_i = 0;
        foreach (d[i]) d[i] = ~d[i];
        beat(d[0]); cyc(); cyc(); beat(d[1]); beat(d[2]);
        check("t3 read_o held", read_o, 1);
        cyc(); beat(d[3]);
        check("t3 resp_o", resp_o, 1);
        check("t3 line_o", line_o, {d[3], d[2], d[1], d[0]});
        cyc();
        // 4: idle resp_i pulses, then simultaneous read/write
        resp_i = 1; cyc(); cyc(); resp_i = 0;
        check("t4 idle resp_o", resp_o, 0);
        read_i = 1; write_i = 1; address_i = 32'h0000_2000; line_i = ~L; cyc();
        read_i = 0; write_i = 0;
        check("t4 write wins", write_o, 1);
        for (int i = 0; i < 4; i++) beat(0);
        cyc();
        // 5: reset after second read beat
        read_i = 1; address_i = 32'h0000_3000; cyc(); read_i = 0;
        beat(64'h1); beat(64'h2);
        rst = 1; cyc(); rst = 0;
        check("t5 read_o", read_o, 0);
        check("t5 line_o", line_o, 0);
        check("t5 address_o", address_o, 0);
        cyc(); cyc();
        check("t5 no resp", resp_o, 0);
        read_i = 1; address_i = 32'h0000_3008; cyc(); read_i = 0;
        for (int i = 0; i < 4; i++) beat(d[i]);
        check("t5 line_o", line_o, {d[3], d[2], d[1], d[0]});
        cyc();
        // 6: back-to-back read, write, read with requests held until resp_o
        for (int k = 0; k < 3; k++) begin
            read_i = (k != 1); write_i = (k == 1);
            address_i = 32'h0000_4000 + k * 32; line_i = L ^ {8{32'(k)}};
            if (k == 1) saved = line_o;
            cyc();
            for (int i = 0; i < 4; i++) beat(d[i] + 64'(k));
            resp_i = 1;
            check("t6 resp_o", resp_o, 1);
            if (k == 1) check("t6 line_o across write", line_o, saved);
            read_i = 0; write_i = 0; cyc(); resp_i = 0;
        end
        check("t6 final line_o", line_o, {d[3] + 64'd2, d[2] + 64'd2, d[1] + 64'd2, d[0] + 64'd2});
        cyc(); cyc();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
